// File: rtl/debouncer_pkg.sv
// Shared types and width helpers for the debouncer bank.
package debouncer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_e;

  // Stability counter only needs to reach STABLE_CYCLES-1.
  function automatic int cnt_width(input int stable_cycles);
    return $clog2(stable_cycles);
  endfunction

  // Hold counter saturates at HOLD_CYCLES, so it needs one extra code.
  function automatic int hold_width(input int hold_cycles);
    return $clog2(hold_cycles + 1);
  endfunction

endpackage

// File: rtl/debouncer_bank_if.sv
// Button bus between board pins and the debouncer bank.
interface debouncer_bank_if #(
  parameter int CHANNELS = 4
) ();
  logic [CHANNELS-1:0] button;
  logic [CHANNELS-1:0] button_out;
  logic [CHANNELS-1:0] press;
  logic [CHANNELS-1:0] release_pulse;
  logic [CHANNELS-1:0] long_press;

  modport master (
    output button,
    input  button_out,
    input  press,
    input  release_pulse,
    input  long_press
  );

  modport slave (
    input  button,
    output button_out,
    output press,
    output release_pulse,
    output long_press
  );
endinterface

// File: rtl/debouncer_channel.sv
// One debounced channel: polarity fix, 2-flop synchroniser, stability FSM
// and long-press hold counter, all outputs registered.
module debouncer_channel
  import debouncer_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter int HOLD_CYCLES   = 1000,
  parameter bit ACTIVE_LOW    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic button_i,
  output logic button_out_o,
  output logic press_o,
  output logic release_o,
  output logic long_press_o
);

  localparam int CNT_W  = cnt_width(STABLE_CYCLES);
  localparam int HCNT_W = hold_width(HOLD_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [HCNT_W-1:0] HOLD_MAX  = HCNT_W'(HOLD_CYCLES);
  localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(HOLD_CYCLES - 1);

  state_e             state_q;
  logic               s1_q, s2_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [HCNT_W-1:0]  hcnt_q, hcnt_d;
  logic               hold_hit;
  logic               button_out_q, press_q, release_q, long_press_q;
  logic               raw;

  assign raw = button_i ^ ACTIVE_LOW;

  // Saturating hold increment; hold_hit marks the step onto HOLD_CYCLES.
  always_comb begin
    hcnt_d   = hcnt_q;
    hold_hit = 1'b0;
    if (hcnt_q != HOLD_MAX) begin
      hcnt_d   = hcnt_q + HCNT_W'(1);
      hold_hit = (hcnt_q == HOLD_LAST);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      hcnt_q       <= '0;
      button_out_q <= 1'b0;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
      long_press_q <= 1'b0;
    end else begin
      s1_q         <= raw;
      s2_q         <= s1_q;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
      long_press_q <= 1'b0;
      case (state_q)
        IDLE: begin
          hcnt_q <= '0;
          if (s2_q) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= CNT_ONE;
          end
        end
        PRESS_WAIT: begin
          if (!s2_q) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q      <= PRESSED;
            cnt_q        <= '0;
            button_out_q <= 1'b1;
            press_q      <= 1'b1;
            hcnt_q       <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        PRESSED: begin
          hcnt_q       <= hcnt_d;
          long_press_q <= hold_hit;
          if (!s2_q) begin
            state_q <= RELEASE_WAIT;
            cnt_q   <= CNT_ONE;
          end
        end
        RELEASE_WAIT: begin
          // A committed release pre-empts a long press landing on the same edge.
          if (!s2_q && cnt_q == CNT_LAST) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            hcnt_q       <= '0;
            button_out_q <= 1'b0;
            release_q    <= 1'b1;
          end else begin
            hcnt_q       <= hcnt_d;
            long_press_q <= hold_hit;
            if (s2_q) begin
              state_q <= PRESSED;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          hcnt_q  <= '0;
        end
      endcase
    end
  end

  assign button_out_o = button_out_q;
  assign press_o      = press_q;
  assign release_o    = release_q;
  assign long_press_o = long_press_q;

endmodule

// File: rtl/debouncer_bank.sv
// Bank of independent debouncer channels; the top only slices the bus.
module debouncer_bank
  import debouncer_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int STABLE_CYCLES = 16,
  parameter int HOLD_CYCLES   = 1000,
  parameter bit ACTIVE_LOW    = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  debouncer_bank_if.slave  bus_if
);

  logic [CHANNELS-1:0] button_out_w;
  logic [CHANNELS-1:0] press_w;
  logic [CHANNELS-1:0] release_w;
  logic [CHANNELS-1:0] long_press_w;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    debouncer_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .HOLD_CYCLES   (HOLD_CYCLES),
      .ACTIVE_LOW    (ACTIVE_LOW)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .button_i     (bus_if.button[gi]),
      .button_out_o (button_out_w[gi]),
      .press_o      (press_w[gi]),
      .release_o    (release_w[gi]),
      .long_press_o (long_press_w[gi])
    );
  end

  assign bus_if.button_out    = button_out_w;
  assign bus_if.press         = press_w;
  assign bus_if.release_pulse = release_w;
  assign bus_if.long_press    = long_press_w;

endmodule

// File: tb/tb_debouncer_bank.sv
// Scoreboard bench: a run-length reference model predicts each cycle's outputs
// for an active-high and an active-low bank driven with the same logical presses.
module tb_debouncer_bank;

  localparam int CH     = 4;
  localparam int STABLE = 4;
  localparam int HOLD   = 20;

  typedef struct packed {
    int            cyc;
    logic [CH-1:0] lvl;
    logic [CH-1:0] prs;
    logic [CH-1:0] rel;
    logic [CH-1:0] lng;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  exp_t exp_q[$];

  // Reference model state: sync delay line, debounced level, run of
  // samples disagreeing with the level, cycles held since the press.
  logic [CH-1:0] m_p1, m_p2, m_lvl;
  int            m_run[CH];
  int            m_age[CH];
  bit            m_fired[CH];

  always #5 clk = ~clk;

  debouncer_bank_if #(.CHANNELS(CH)) bus_h ();
  debouncer_bank_if #(.CHANNELS(CH)) bus_l ();

  debouncer_bank #(
    .CHANNELS(CH), .STABLE_CYCLES(STABLE), .HOLD_CYCLES(HOLD), .ACTIVE_LOW(1'b0)
  ) dut_h (
    .clk(clk), .rst(rst), .bus_if(bus_h)
  );

  debouncer_bank #(
    .CHANNELS(CH), .STABLE_CYCLES(STABLE), .HOLD_CYCLES(HOLD), .ACTIVE_LOW(1'b1)
  ) dut_l (
    .clk(clk), .rst(rst), .bus_if(bus_l)
  );

  task automatic model_reset();
    m_p1 = '0;
    m_p2 = '0;
    m_lvl = '0;
    for (int i = 0; i < CH; i++) begin
      m_run[i] = 0;
      m_age[i] = 0;
      m_fired[i] = 1'b0;
    end
  endtask

  // Predict outputs after the coming edge given the pressed vector now applied.
  task automatic model_step(input logic [CH-1:0] pr, output exp_t e);
    logic [CH-1:0] smp;
    bit was;
    smp  = m_p2;
    m_p2 = m_p1;
    m_p1 = pr;
    e = '0;
    for (int i = 0; i < CH; i++) begin
      was = m_lvl[i];
      if (smp[i] != m_lvl[i]) m_run[i]++;
      else m_run[i] = 0;
      if (m_run[i] == STABLE) begin
        m_lvl[i] = ~m_lvl[i];
        m_run[i] = 0;
        if (m_lvl[i]) begin
          e.prs[i] = 1'b1;
          m_age[i] = 0;
          m_fired[i] = 1'b0;
        end else begin
          e.rel[i] = 1'b1;
        end
      end else if (was) begin
        m_age[i]++;
        if (m_age[i] == HOLD && !m_fired[i]) begin
          e.lng[i] = 1'b1;
          m_fired[i] = 1'b1;
        end
      end
    end
    e.lvl = m_lvl;
  endtask

  task automatic compare(input string name, input int c,
                         input logic [CH-1:0] lvl, input logic [CH-1:0] prs,
                         input logic [CH-1:0] rel, input logic [CH-1:0] lng,
                         input exp_t e);
    n_cmp++;
    if ({lvl, prs, rel, lng} !== {e.lvl, e.prs, e.rel, e.lng}) begin
      n_bad++;
      $display("FAIL %s cyc=%0d lvl/press/release/long actual=%b/%b/%b/%b required=%b/%b/%b/%b",
               name, c, lvl, prs, rel, lng, e.lvl, e.prs, e.rel, e.lng);
    end
  endtask

  task automatic check_zero(input string name);
    exp_t z;
    z = '0;
    compare({name, "_high"}, cyc, bus_h.button_out, bus_h.press,
            bus_h.release_pulse, bus_h.long_press, z);
    compare({name, "_low"}, cyc, bus_l.button_out, bus_l.press,
            bus_l.release_pulse, bus_l.long_press, z);
  endtask

  task automatic drive(input logic [CH-1:0] pr, input bit r);
    exp_t e;
    bit   rising;
    @(negedge clk);
    cyc++;
    bus_h.button = pr;
    bus_l.button = ~pr;
    rising = r && !rst;
    rst = r;
    if (r) begin
      model_reset();
      e = '0;
    end else begin
      model_step(pr, e);
    end
    e.cyc = cyc;
    exp_q.push_back(e);
    if (rising) begin
      #1;
      check_zero("async_reset");
    end
  endtask

  task automatic hold(input logic [CH-1:0] pr, input int n);
    for (int k = 0; k < n; k++) drive(pr, 1'b0);
  endtask

  // Monitor: every edge the DUTs present a full output word; compare to the queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compare("active_high", e.cyc, bus_h.button_out, bus_h.press,
                bus_h.release_pulse, bus_h.long_press, e);
        compare("active_low", e.cyc, bus_l.button_out, bus_l.press,
                bus_l.release_pulse, bus_l.long_press, e);
      end
    end
  end

  initial begin
    logic [CH-1:0] cur;
    int            left[CH];
    rst = 1'b1;
    bus_h.button = '0;
    bus_l.button = '1;
    model_reset();
    #2;
    check_zero("reset_state");
    for (int k = 0; k < 3; k++) drive('0, 1'b1);

    // Press on ch0 with long press, release glitch, then real release.
    hold(4'b0001, 30);
    hold(4'b0000, 2);
    hold(4'b0001, 10);
    hold(4'b0000, 10);
    // Short glitch on ch1 is rejected.
    hold(4'b0010, 3);
    hold(4'b0000, 10);
    // Simultaneous press and release on ch2/ch3.
    hold(4'b1100, 10);
    hold(4'b0000, 10);
    // Reset while ch0 pressed with hold mid-count, then fresh press.
    hold(4'b0001, 15);
    drive(4'b0001, 1'b1);
    drive(4'b0001, 1'b1);
    hold(4'b0001, 12);
    hold(4'b0000, 10);

    // Random per-channel runs, short ones below the filter and long holds.
    cur = '0;
    for (int i = 0; i < CH; i++) left[i] = 0;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < CH; i++) begin
        if (left[i] == 0) begin
          cur[i] = ~cur[i];
          left[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(25, 40))
                                                : int'($urandom_range(1, 8));
        end
        left[i]--;
      end
      drive(cur, $urandom_range(0, 399) == 0);
    end
    hold('0, 10);

    @(posedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
